// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus controller.
//   state_e      : controller FSM states
//   DEF_CS_*     : default chip-select timing, in clk cycles
//   cnt_width()  : width of a delay counter able to reach every timing value
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT,
        HOLD,
        GAP
    } state_e;

    localparam int unsigned DEF_CS_SETUP = 4;
    localparam int unsigned DEF_CS_HOLD  = 4;
    localparam int unsigned DEF_CS_GAP   = 8;

    // Counters only ever reach (value - 1), so $clog2 of the largest value suffices.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : request vector
//   last_grant : index of the most recent winner; search starts one above it
//   grant      : one-hot winner, all zero when nothing is requested
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((32'(last_grant) + i) % NUM_REQ);
            if (grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_bus_ctrl.sv
// SPI bus controller: shares one byte engine between NUM_REQ requesters.
// A requester raises req, is granted round-robin, gets its chip select after
// arbitration and then streams bytes through the engine until tx_last or
// until it drops req. Chip-select setup/hold/gap timing is parameterised.
//   clk, rst            : clock, synchronous active-high reset
//   req / gnt           : per-requester request level / one-hot grant
//   tx_valid/data/last  : byte offer from each requester; tx_ready accepts it
//   rx_valid / rx_data  : byte returned by the engine for the granted requester
//   cs_n                : per-requester active-low chip select
//   eng_begin/eng_data  : start pulse and byte to the engine
//   eng_end / eng_rx    : completion pulse and received byte from the engine
module spi_bus_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned CS_SETUP = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
    parameter int unsigned CS_GAP   = DEF_CS_GAP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic [NUM_REQ-1:0]   tx_valid,
    input  logic [8*NUM_REQ-1:0] tx_data,
    input  logic [NUM_REQ-1:0]   tx_last,
    output logic [NUM_REQ-1:0]   tx_ready,
    output logic                 rx_valid,
    output logic [7:0]           rx_data,
    output logic [NUM_REQ-1:0]   cs_n,
    output logic                 eng_begin,
    output logic [7:0]           eng_data,
    input  logic                 eng_end,
    input  logic [7:0]           eng_rx
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = cnt_width(CS_SETUP, CS_HOLD, CS_GAP);

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        last_grant_q;
    logic [IW-1:0]        g_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [NUM_REQ-1:0]   cs_n_q;
    logic [NUM_REQ-1:0]   tx_ready_q;
    logic                 rx_valid_q;
    logic                 eng_begin_q;
    logic                 last_flag_q;
    logic [7:0]           eng_data_q;
    logic [7:0]           rx_data_q;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 setup_done;
    logic                 hold_done;
    logic                 gap_done;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req       (req),
        .last_grant(last_grant_q),
        .grant     (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) arb_idx = IW'(i);
        end
    end

    // CS_SETUP spans cs_n low to eng_begin; the SEND cycle that issues
    // eng_begin is part of it, so SETUP itself lasts one cycle less.
    // CS_HOLD spans the edge sampling eng_end to cs_n high, all in HOLD.
    // A value of 0 still leaves one cycle in the state.
    assign setup_done = (32'(cnt_q) + 32'd2) >= CS_SETUP;
    assign hold_done  = (32'(cnt_q) + 32'd1) >= CS_HOLD;
    assign gap_done   = (32'(cnt_q) + 32'd1) >= CS_GAP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= IW'(NUM_REQ - 1);
            g_q          <= '0;
            gnt_q        <= '0;
            cs_n_q       <= '1;
            tx_ready_q   <= '0;
            rx_valid_q   <= 1'b0;
            eng_begin_q  <= 1'b0;
            last_flag_q  <= 1'b0;
            eng_data_q   <= '0;
            rx_data_q    <= '0;
        end else begin
            tx_ready_q  <= '0;
            rx_valid_q  <= 1'b0;
            eng_begin_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q        <= arb_grant;
                        cs_n_q       <= ~arb_grant;
                        g_q          <= arb_idx;
                        last_grant_q <= arb_idx;
                        cnt_q        <= '0;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    if (setup_done) begin
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SEND: begin
                    if (tx_valid[g_q]) begin
                        tx_ready_q[g_q] <= 1'b1;
                        eng_data_q      <= tx_data[{g_q, 3'b000} +: 8];
                        last_flag_q     <= tx_last[g_q];
                        eng_begin_q     <= 1'b1;
                        state_q         <= WAIT;
                    end else if (!req[g_q]) begin
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end
                end
                WAIT: begin
                    // req is only looked at once the byte completes, so a
                    // dropped request never cuts a byte short.
                    if (eng_end) begin
                        rx_data_q  <= eng_rx;
                        rx_valid_q <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= (last_flag_q || !req[g_q]) ? HOLD : SEND;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        cs_n_q  <= '1;
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign cs_n      = cs_n_q;
    assign tx_ready  = tx_ready_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign eng_begin = eng_begin_q;
    assign eng_data  = eng_data_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Directed bench for spi_bus_ctrl with a 20-cycle byte engine returning ~eng_data.
module tb_spi_bus_ctrl;

    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_GAP   = 8;
    localparam int ENG_LAT  = 20;

    localparam int W_CS0_LO = 0;
    localparam int W_CS0_HI = 1;
    localparam int W_CS1_LO = 2;
    localparam int W_CS1_HI = 3;
    localparam int W_BEGIN  = 4;
    localparam int W_END    = 5;
    localparam int W_RXV    = 6;
    localparam int W_GNT1   = 7;
    localparam int W_GNTANY = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic [1:0]  tx_valid = 2'b00;
    logic [15:0] tx_data = 16'h0000;
    logic [1:0]  tx_last = 2'b00;
    logic [1:0]  tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  cs_n;
    logic        eng_begin;
    logic [7:0]  eng_data;
    logic        eng_end = 1'b0;
    logic [7:0]  eng_rx = 8'h00;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_begin  = 0;
    int          n_ready  = 0;
    bit          mon_en   = 1'b0;
    bit [1:0]    stall    = 2'b00;
    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [7:0]  rxlog[$];

    spi_bus_ctrl #(
        .NUM_REQ (2),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .cs_n     (cs_n),
        .eng_begin(eng_begin),
        .eng_data (eng_data),
        .eng_end  (eng_end),
        .eng_rx   (eng_rx)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Requesters: offer the head of each queue, pop it when tx_ready is seen.
    initial forever begin
        @(negedge clk);
        if (tx_ready[0] && q0.size() > 0) void'(q0.pop_front());
        if (tx_ready[1] && q1.size() > 0) void'(q1.pop_front());
        tx_valid[0]   = (q0.size() > 0) && !stall[0];
        tx_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
        tx_last[0]    = (q0.size() == 1);
        tx_valid[1]   = (q1.size() > 0) && !stall[1];
        tx_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
        tx_last[1]    = (q1.size() == 1);
    end

    // Byte engine: eng_end ENG_LAT cycles after eng_begin, returning ~eng_data.
    initial begin
        int         eng_cnt;
        logic [7:0] eng_byte;
        eng_cnt  = 0;
        eng_byte = 8'h00;
        forever begin
            @(negedge clk);
            eng_end = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_end = 1'b1;
                    eng_rx  = eng_byte;
                end
            end
            if (eng_begin === 1'b1) begin
                eng_cnt  = ENG_LAT;
                eng_byte = ~eng_data;
            end
        end
    end

    // Every-cycle protocol checks, sampled mid-low-phase after all drivers settle.
    initial begin
        bit busy;
        busy = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                n_assert++;
                if ($onehot0(~cs_n) !== 1'b1) begin
                    n_fail++; $display("FAIL mon_cs_onehot: cs_n=%b at cycle %0d", cs_n, cyc);
                end
                n_assert++;
                if ($onehot0(gnt) !== 1'b1) begin
                    n_fail++; $display("FAIL mon_gnt_onehot: gnt=%b at cycle %0d", gnt, cyc);
                end
                n_assert++;
                if (gnt !== ~cs_n) begin
                    n_fail++; $display("FAIL mon_gnt_cs: gnt=%b cs_n=%b at cycle %0d", gnt, cs_n, cyc);
                end
                n_assert++;
                if ((tx_ready & ~gnt) !== 2'b00) begin
                    n_fail++; $display("FAIL mon_ready_gnt: tx_ready=%b gnt=%b at cycle %0d", tx_ready, gnt, cyc);
                end
                n_assert++;
                if (eng_begin === 1'b1 && busy) begin
                    n_fail++; $display("FAIL mon_begin_busy: eng_begin=1 while engine busy at cycle %0d", cyc);
                end
            end
            if (eng_begin === 1'b1) n_begin++;
            if (tx_ready !== 2'b00) n_ready++;
            if (eng_begin === 1'b1) busy = 1'b1;
            else if (eng_end) busy = 1'b0;
            if (rx_valid === 1'b1) rxlog.push_back(rx_data);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_for(input int sel, input int limit, output bit ok);
        bit hit;
        ok = 1'b0;
        for (int k = 0; k <= limit; k++) begin
            case (sel)
                W_CS0_LO: hit = (cs_n[0] === 1'b0);
                W_CS0_HI: hit = (cs_n[0] === 1'b1);
                W_CS1_LO: hit = (cs_n[1] === 1'b0);
                W_CS1_HI: hit = (cs_n[1] === 1'b1);
                W_BEGIN:  hit = (eng_begin === 1'b1);
                W_END:    hit = (eng_end === 1'b1);
                W_RXV:    hit = (rx_valid === 1'b1);
                W_GNT1:   hit = (gnt === 2'b10);
                W_GNTANY: hit = (gnt === 2'b01 || gnt === 2'b10);
                default:  hit = 1'b0;
            endcase
            if (hit) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b00;
        repeat (3) @(negedge clk);
        n_assert++; if (cs_n !== 2'b11) begin n_fail++; $display("FAIL reset_cs_n: got %b required 11", cs_n); end
        n_assert++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b required 00", gnt); end
        n_assert++; if (tx_ready !== 2'b00) begin n_fail++; $display("FAIL reset_tx_ready: got %b required 00", tx_ready); end
        n_assert++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
        n_assert++; if (eng_begin !== 1'b0) begin n_fail++; $display("FAIL reset_eng_begin: got %b required 0", eng_begin); end
        n_assert++; if (eng_data !== 8'h00) begin n_fail++; $display("FAIL reset_eng_data: got %h required 00", eng_data); end
        n_assert++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
        mon_en = 1'b1;
    endtask

    task automatic test_contention();
        bit ok;
        int t_rise, t_g;
        rxlog.delete();
        q0.push_back(8'h11);
        q1.push_back(8'h22);
        req = 2'b11;
        rst = 1'b0;
        wait_for(W_CS0_LO, 20, ok);
        n_assert++; if (!ok || gnt !== 2'b01 || cs_n !== 2'b10) begin
            n_fail++; $display("FAIL cont_first_grant: ok=%0b gnt=%b cs_n=%b required gnt=01 cs_n=10", ok, gnt, cs_n);
        end
        wait_for(W_CS0_HI, 100, ok);
        t_rise = cyc;
        req[0] = 1'b0;
        wait_for(W_GNT1, 40, ok);
        t_g = cyc;
        // GAP holds CS_GAP cycles, then IDLE registers the next grant one cycle later.
        n_assert++; if (!ok || (t_g - t_rise) != CS_GAP + 1) begin
            n_fail++; $display("FAIL cont_gap: ok=%0b grant delay=%0d required %0d", ok, t_g - t_rise, CS_GAP + 1);
        end
        n_assert++; if (cs_n !== 2'b01) begin n_fail++; $display("FAIL cont_cs1: got %b required 01", cs_n); end
        wait_for(W_CS1_HI, 100, ok);
        q0.push_back(8'h33);
        q1.push_back(8'h44);
        req = 2'b11;
        wait_for(W_GNTANY, 40, ok);
        n_assert++; if (!ok || gnt !== 2'b01) begin
            n_fail++; $display("FAIL cont_rr_second: ok=%0b gnt=%b required 01", ok, gnt);
        end
        wait_for(W_CS0_HI, 100, ok);
        req[0] = 1'b0;
        wait_for(W_CS1_LO, 40, ok);
        wait_for(W_CS1_HI, 100, ok);
        req = 2'b00;
        n_assert++; if (rxlog.size() != 4 || rxlog[0] !== 8'hEE || rxlog[1] !== 8'hDD || rxlog[2] !== 8'hCC || rxlog[3] !== 8'hBB) begin
            n_fail++; $display("FAIL cont_rx: got %p required EE DD CC BB", rxlog);
        end
        repeat (CS_GAP + 4) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        int t_cs, t_b, t_e, t_r;
        rxlog.delete();
        q0.push_back(8'hA5);
        q0.push_back(8'h3C);
        req[0] = 1'b1;
        wait_for(W_CS0_LO, 20, ok);
        t_cs = cyc;
        n_assert++; if (!ok || gnt !== 2'b01) begin n_fail++; $display("FAIL single_grant: ok=%0b gnt=%b required 01", ok, gnt); end
        wait_for(W_BEGIN, 20, ok);
        t_b = cyc;
        n_assert++; if (!ok || (t_b - t_cs) != CS_SETUP) begin
            n_fail++; $display("FAIL single_setup: ok=%0b delay=%0d required %0d", ok, t_b - t_cs, CS_SETUP);
        end
        n_assert++; if (eng_data !== 8'hA5) begin n_fail++; $display("FAIL single_byte0: eng_data=%h required a5", eng_data); end
        @(negedge clk);
        wait_for(W_BEGIN, 40, ok);
        n_assert++; if (!ok || eng_data !== 8'h3C) begin
            n_fail++; $display("FAIL single_byte1: ok=%0b eng_data=%h required 3c", ok, eng_data);
        end
        wait_for(W_END, 40, ok);
        t_e = cyc + 1;  // edge that samples eng_end
        wait_for(W_CS0_HI, 20, ok);
        t_r = cyc;
        n_assert++; if (!ok || (t_r - t_e) != CS_HOLD) begin
            n_fail++; $display("FAIL single_hold: ok=%0b delay=%0d required %0d", ok, t_r - t_e, CS_HOLD);
        end
        req[0] = 1'b0;
        n_assert++; if (rxlog.size() != 2 || rxlog[0] !== 8'h5A || rxlog[1] !== 8'hC3) begin
            n_fail++; $display("FAIL single_rx: got %p required 5A C3", rxlog);
        end
        repeat (CS_GAP + 4) @(negedge clk);
    endtask

    task automatic test_rr_after0();
        bit ok;
        rxlog.delete();
        q0.push_back(8'h01);
        q1.push_back(8'h02);
        req = 2'b11;
        wait_for(W_GNTANY, 20, ok);
        n_assert++; if (!ok || gnt !== 2'b10) begin n_fail++; $display("FAIL rr_first: ok=%0b gnt=%b required 10", ok, gnt); end
        wait_for(W_CS1_HI, 100, ok);
        req[1] = 1'b0;
        wait_for(W_GNTANY, 40, ok);
        n_assert++; if (!ok || gnt !== 2'b01) begin n_fail++; $display("FAIL rr_second: ok=%0b gnt=%b required 01", ok, gnt); end
        wait_for(W_CS0_HI, 100, ok);
        req = 2'b00;
        n_assert++; if (rxlog.size() != 2 || rxlog[0] !== 8'hFD || rxlog[1] !== 8'hFE) begin
            n_fail++; $display("FAIL rr_rx: got %p required FD FE", rxlog);
        end
        repeat (CS_GAP + 4) @(negedge clk);
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        rxlog.delete();
        q0.push_back(8'h55);
        q0.push_back(8'h66);
        q0.push_back(8'h77);
        req[0] = 1'b1;
        wait_for(W_BEGIN, 40, ok);
        stall[0] = 1'b1;
        wait_for(W_RXV, 40, ok);
        n_assert++; if (!ok || rx_data !== 8'hAA) begin n_fail++; $display("FAIL stall_first_rx: ok=%0b rx_data=%h required aa", ok, rx_data); end
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs_n[0] !== 1'b0 || eng_begin !== 1'b0 || tx_ready !== 2'b00) bad++;
        end
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d bad cycles required 0", bad); end
        stall[0] = 1'b0;
        wait_for(W_BEGIN, 10, ok);
        n_assert++; if (!ok || eng_data !== 8'h66) begin n_fail++; $display("FAIL stall_resume: ok=%0b eng_data=%h required 66", ok, eng_data); end
        wait_for(W_CS0_HI, 200, ok);
        req[0] = 1'b0;
        n_assert++; if (rxlog.size() != 3 || rxlog[0] !== 8'hAA || rxlog[1] !== 8'h99 || rxlog[2] !== 8'h88) begin
            n_fail++; $display("FAIL stall_rx: got %p required AA 99 88", rxlog);
        end
        repeat (CS_GAP + 4) @(negedge clk);
    endtask

    task automatic test_abort_wait();
        bit ok;
        int t_e, t_r, nb0;
        rxlog.delete();
        nb0 = n_begin;
        q0.push_back(8'h12);
        q0.push_back(8'h34);
        req[0] = 1'b1;
        wait_for(W_BEGIN, 40, ok);
        n_assert++; if (!ok || eng_data !== 8'h12) begin n_fail++; $display("FAIL abort_begin: ok=%0b eng_data=%h required 12", ok, eng_data); end
        repeat (5) @(negedge clk);
        req[0] = 1'b0;
        wait_for(W_END, 40, ok);
        t_e = cyc + 1;
        @(negedge clk);
        n_assert++; if (rx_valid !== 1'b1 || rx_data !== 8'hED) begin
            n_fail++; $display("FAIL abort_rx: rx_valid=%b rx_data=%h required 1/ed", rx_valid, rx_data);
        end
        wait_for(W_CS0_HI, 20, ok);
        t_r = cyc;
        n_assert++; if (!ok || (t_r - t_e) != CS_HOLD) begin
            n_fail++; $display("FAIL abort_hold: ok=%0b delay=%0d required %0d", ok, t_r - t_e, CS_HOLD);
        end
        n_assert++; if ((n_begin - nb0) != 1) begin n_fail++; $display("FAIL abort_begins: got %0d required 1", n_begin - nb0); end
        q0.delete();
        repeat (CS_GAP + 4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n_rx;
        rxlog.delete();
        q0.push_back(8'h9A);
        q0.push_back(8'hBC);
        req[0] = 1'b1;
        wait_for(W_BEGIN, 40, ok);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_assert++; if (cs_n !== 2'b11 || gnt !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_deselect: cs_n=%b gnt=%b required 11/00", cs_n, gnt);
        end
        n_assert++; if (eng_data !== 8'h00 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_data: eng_data=%h rx_data=%h required 00/00", eng_data, rx_data);
        end
        rst = 1'b0;
        req = 2'b00;
        q0.delete();
        n_rx = 0;
        repeat (30) begin
            @(negedge clk);
            if (rx_valid !== 1'b0) n_rx++;
        end
        n_assert++; if (n_rx != 0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_late_end: rx_valid pulses=%0d rx_data=%h required 0/00", n_rx, rx_data);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_rr_after0();
        test_stall();
        test_abort_wait();
        test_reset_mid();
        @(negedge clk);
        #3;
        n_assert++; if (n_begin != n_ready) begin
            n_fail++; $display("FAIL begin_ready_count: eng_begin=%0d tx_ready=%0d required equal", n_begin, n_ready);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
